fetch_decode: RTL

Two-stage fetch/decode front end for the 8-bit processor. It owns the program counter, latches the fetched 32-bit instruction into a decode register and decodes it into register-file addresses, write enable, immediate and ALU controls. These outputs drive the register file and ALU directly downstream. It also resolves jumps and branches, squashing the wrong-path instruction, and halts on illegal opcodes.

---
 rtl/fetch_decode_if.sv | 39 +++
 rtl/fetch_decode.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory and decode-output bundle of the
// fetch/decode front end.
//   master : the front end. It drives PC and the decode outputs and
//            receives INSTRUCTION and ZERO.
//   slave  : the surroundings (instruction memory, register file, ALU).
// Signals:
//   INSTRUCTION  32-bit word at PC, combinational from instruction memory
//   ZERO         ALU zero flag for the instruction currently in decode
//   PC           fetch address
//   INADDRESS / OUT1ADDRESS / OUT2ADDRESS  register-file addresses
//   IMMEDIATE    8-bit immediate field
//   WRITE, ALUOP, NEG_SEL, IMM_SEL          register-file / ALU controls
//   HALTED       core stopped on an illegal opcode
interface fetch_decode_if;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] PC;
    logic [2:0]  INADDRESS;
    logic [2:0]  OUT1ADDRESS;
    logic [2:0]  OUT2ADDRESS;
    logic [7:0]  IMMEDIATE;
    logic        WRITE;
    logic [2:0]  ALUOP;
    logic        NEG_SEL;
    logic        IMM_SEL;
    logic        HALTED;

    modport master (
        input  INSTRUCTION, ZERO,
        output PC, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE,
               WRITE, ALUOP, NEG_SEL, IMM_SEL, HALTED
    );

    modport slave (
        output INSTRUCTION, ZERO,
        input  PC, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE,
               WRITE, ALUOP, NEG_SEL, IMM_SEL, HALTED
    );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: two-stage fetch/decode front end of the 8-bit processor.
// It owns the program counter and latches the fetched instruction into a
// decode register (IR, DPC = fetch PC + 4, valid bit). It decodes IR into
// register-file addresses, write enable, immediate and ALU controls. Taken
// j/beq instructions redirect the PC and squash the wrong-path fetch. An
// illegal opcode in decode stops the core until reset.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-low reset
//   bus    fetch_decode_if.master (PC, INSTRUCTION, ZERO, decode outputs)
// Parameter:
//   PC_RESET  PC value loaded on reset
module fetch_decode #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RESET,
    fetch_decode_if.master  bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    state_t      state_r, state_n_s;
    logic [31:0] pc_r, pc_n_s;
    logic [31:0] ir_r, ir_n_s;
    logic [31:0] dpc_r, dpc_n_s;
    logic        v_r, v_n_s;

    logic [7:0]  opcode_s;
    logic        write_raw_s;
    logic [2:0]  aluop_raw_s;
    logic        neg_raw_s;
    logic        imm_raw_s;
    logic        illegal_s;
    logic        active_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    assign opcode_s   = ir_r[31:24];
    assign pc_plus4_s = pc_r + 32'd4;   // wraps FFFF_FFFC -> 0 naturally
    // Offset is a signed word count: sign-extend, then scale by 4.
    assign target_s   = dpc_r + {{22{ir_r[23]}}, ir_r[23:16], 2'b00};
    assign active_s   = v_r && (state_r == ST_RUN);
    assign taken_s    = v_r && ((opcode_s == OP_J) ||
                                ((opcode_s == OP_BEQ) && bus.ZERO));

    // Raw opcode decode, before gating by valid/halted.
    always_comb begin
        write_raw_s = 1'b0;
        aluop_raw_s = ALU_FWD;
        neg_raw_s   = 1'b0;
        imm_raw_s   = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_LOADI: begin
                imm_raw_s   = 1'b1;
                write_raw_s = 1'b1;
            end
            OP_MOV: begin
                write_raw_s = 1'b1;
            end
            OP_ADD: begin
                aluop_raw_s = ALU_ADD;
                write_raw_s = 1'b1;
            end
            OP_SUB: begin
                aluop_raw_s = ALU_ADD;
                neg_raw_s   = 1'b1;
                write_raw_s = 1'b1;
            end
            OP_AND: begin
                aluop_raw_s = ALU_AND;
                write_raw_s = 1'b1;
            end
            OP_OR: begin
                aluop_raw_s = ALU_OR;
                write_raw_s = 1'b1;
            end
            OP_J: begin
                write_raw_s = 1'b0;
            end
            OP_BEQ: begin
                aluop_raw_s = ALU_ADD;
                neg_raw_s   = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Controls are forced inactive for a bubble or a halted core; the
    // address and immediate fields pass through from IR unconditionally.
    assign bus.WRITE       = write_raw_s & active_s;
    assign bus.NEG_SEL     = neg_raw_s & active_s;
    assign bus.IMM_SEL     = imm_raw_s & active_s;
    assign bus.ALUOP       = active_s ? aluop_raw_s : ALU_FWD;
    assign bus.INADDRESS   = ir_r[18:16];
    assign bus.OUT1ADDRESS = ir_r[10:8];
    assign bus.OUT2ADDRESS = ir_r[2:0];
    assign bus.IMMEDIATE   = ir_r[7:0];
    assign bus.PC          = pc_r;
    assign bus.HALTED      = (state_r == ST_HALT);

    // Next-state logic: illegal halt beats branch, branch beats sequential fetch.
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        ir_n_s    = ir_r;
        dpc_n_s   = dpc_r;
        v_n_s     = v_r;
        case (state_r)
            ST_RUN: begin
                if (v_r && illegal_s) begin
                    state_n_s = ST_HALT;
                    v_n_s     = 1'b0;
                end else if (taken_s) begin
                    pc_n_s = target_s;
                    v_n_s  = 1'b0;      // squash the wrong-path fetch
                end else begin
                    ir_n_s  = bus.INSTRUCTION;
                    dpc_n_s = pc_plus4_s;
                    v_n_s   = 1'b1;
                    pc_n_s  = pc_plus4_s;
                end
            end
            ST_HALT: begin
                state_n_s = ST_HALT;
            end
            default: begin
                state_n_s = ST_RUN;
            end
        endcase
    end

    // State, PC and decode register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_RUN;
            pc_r    <= PC_RESET;
            ir_r    <= 32'h0000_0000;
            dpc_r   <= 32'h0000_0000;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            ir_r    <= ir_n_s;
            dpc_r   <= dpc_n_s;
            v_r     <= v_n_s;
        end
    end

endmodule
